// File: rtl/multdiv_sequencer.sv
// Issue/commit sequencer for the shared multi-cycle mul/div unit: start pulses,
// result buffering, regfile-port arbitration and FD hazard stall. Optional RUN
// watchdog is enabled with MULTDIV_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no op in flight, issue may be accepted
// START | one cycle, ctrl_MULT/ctrl_DIV pulse high
// RUN   | waiting for md_ready from the unit
// DONE  | buffered result/exception waits for a free write port
module multdiv_sequencer #(
  parameter int RSTATUS_REG = 30,
  parameter int EXC_MUL     = 4,
  parameter int EXC_DIV     = 5,
  parameter int TIMEOUT     = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_is_div,
  input  logic [4:0]  issue_rd,
  output logic        issue_accept,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  input  logic        fd_valid,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic [4:0]  fd_rd,
  input  logic        wb_busy,
  output logic        stall,
  output logic        busy,
  output logic        commit,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_data
);

  localparam logic [4:0]  LP_RSTATUS = 5'(RSTATUS_REG);
  localparam logic [31:0] LP_EXC_MUL = 32'(EXC_MUL);
  localparam logic [31:0] LP_EXC_DIV = 32'(EXC_DIV);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_pend_rd;
  logic        r_is_div;
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_ctrl_mult;
  logic        r_ctrl_div;
  logic        w_accept;
  logic        w_capture;
  logic        w_timeout;
  logic        w_commit;
  logic        w_rd_hit;
  logic        w_rstatus_hit;

`ifdef MULTDIV_TIMEOUT_EN
  logic [7:0] r_run_cnt;

  assign w_timeout = (r_state == RUN) && !md_ready && (r_run_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (reset)                 r_run_cnt <= '0;
    else if (r_state == START) r_run_cnt <= '0;
    else if (r_state == RUN)   r_run_cnt <= r_run_cnt + 8'd1;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_timeout        = 1'b0;
`endif

  assign w_accept  = issue_valid && (r_state == IDLE);
  assign w_capture = (r_state == RUN) && md_ready;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_commit      = 1'b0;
    w_rd_hit      = 1'b0;
    w_rstatus_hit = 1'b0;
    case (r_state)
      IDLE:  if (w_accept) w_next_state = START;
      START: w_next_state = RUN;
      RUN:   if (w_capture || w_timeout) w_next_state = DONE;
      DONE: begin
        // a zero-rd result without exception leaves here silently
        w_commit = !wb_busy && (r_exc || (r_pend_rd != 5'd0));
        if (!wb_busy) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if ((r_state != IDLE) && fd_valid) begin
      w_rd_hit      = (r_pend_rd != 5'd0) &&
                      ((fd_rs == r_pend_rd) || (fd_rt == r_pend_rd) || (fd_rd == r_pend_rd));
      w_rstatus_hit = (fd_rd == LP_RSTATUS);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ctrl_mult <= 1'b0;
      r_ctrl_div  <= 1'b0;
      r_pend_rd   <= '0;
      r_is_div    <= 1'b0;
      r_result    <= '0;
      r_exc       <= 1'b0;
    end else begin
      r_ctrl_mult <= w_accept && !issue_is_div;
      r_ctrl_div  <= w_accept && issue_is_div;
      if (w_accept) begin
        r_pend_rd <= issue_rd;
        r_is_div  <= issue_is_div;
      end
      if (w_capture) begin
        r_result <= md_result;
        r_exc    <= md_exception;
      end else if (w_timeout) begin
        r_exc <= 1'b1;
      end
    end
  end

  assign issue_accept = w_accept;
  assign ctrl_MULT    = r_ctrl_mult;
  assign ctrl_DIV     = r_ctrl_div;
  assign busy         = (r_state != IDLE);
  assign commit       = w_commit;
  // the pending-rd hazard clears on the commit cycle since the write lands now
  assign stall        = (issue_valid && (r_state != IDLE)) || (w_rd_hit && !w_commit) || w_rstatus_hit;
  assign commit_rd    = !w_commit ? 5'd0 : (r_exc ? LP_RSTATUS : r_pend_rd);
  assign commit_data  = !w_commit ? 32'd0 :
                        (r_exc ? (r_is_div ? LP_EXC_DIV : LP_EXC_MUL) : r_result);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer: per-cycle vector table plus hand-written
// back-to-back, reset-abort and RUN-timeout sequences.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_is_div;
  logic [4:0]  issue_rd;
  logic        issue_accept, ctrl_MULT, ctrl_DIV;
  logic        md_ready, md_exception;
  logic [31:0] md_result;
  logic        fd_valid;
  logic [4:0]  fd_rs, fd_rt, fd_rd;
  logic        wb_busy;
  logic        stall, busy, commit;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;

  int n_cmp = 0;
  int n_bad = 0;

  multdiv_sequencer dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_rd(issue_rd),
    .issue_accept(issue_accept), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .md_ready(md_ready), .md_exception(md_exception), .md_result(md_result),
    .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_rd(fd_rd),
    .wb_busy(wb_busy), .stall(stall), .busy(busy), .commit(commit),
    .commit_rd(commit_rd), .commit_data(commit_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit iv; bit idiv; bit [4:0] ird;
    bit rdy; bit exc; bit [31:0] res;
    bit fv; bit [4:0] rs; bit [4:0] rt; bit [4:0] frd;
    bit wb;
    bit e_acc; bit e_mul; bit e_div; bit e_stall; bit e_busy; bit e_com;
    bit [4:0] e_crd; bit [31:0] e_cdata;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit iv, bit idiv, bit [4:0] ird, bit rdy, bit exc, bit [31:0] res,
                              bit fv, bit [4:0] rs, bit [4:0] rt, bit [4:0] frd, bit wb,
                              bit e_acc, bit e_mul, bit e_div, bit e_stall, bit e_busy,
                              bit e_com, bit [4:0] e_crd, bit [31:0] e_cdata);
    vec_t v;
    v = '{iv, idiv, ird, rdy, exc, res, fv, rs, rt, frd, wb,
          e_acc, e_mul, e_div, e_stall, e_busy, e_com, e_crd, e_cdata};
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_is_div = 0; issue_rd = 0;
    md_ready = 0; md_exception = 0; md_result = 0;
    fd_valid = 0; fd_rs = 0; fd_rt = 0; fd_rd = 0; wb_busy = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected $finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int ccyc;
    logic [4:0]  crd;
    logic [31:0] cdata;

    //   iv dv rd  rdy ex res      fv rs rt frd wb  acc mul div stl bsy com crd cdata
    add(1, 0, 5,  0, 0, 0,       0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0,  0);     // 0  mul r5
    add(0, 0, 0,  0, 0, 0,       1, 5, 0, 0,  0,  0, 1, 0, 1, 1, 0, 0,  0);     // 1  START, RAW rs
    add(0, 0, 0,  0, 0, 0,       1, 0, 5, 0,  0,  0, 0, 0, 1, 1, 0, 0,  0);     // 2  RAW rt
    add(0, 0, 0,  0, 0, 0,       1, 4, 6, 9,  0,  0, 0, 0, 0, 1, 0, 0,  0);     // 3  independent
    add(0, 0, 0,  0, 0, 0,       1, 0, 0, 30, 0,  0, 0, 0, 1, 1, 0, 0,  0);     // 4  rstatus guard
    add(0, 0, 0,  0, 0, 0,       0, 5, 0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  0);     // 5  bubble
    add(0, 0, 0,  1, 0, 'h54,    1, 5, 0, 0,  0,  0, 0, 0, 1, 1, 0, 0,  0);     // 6  ready, no commit
    add(0, 0, 0,  0, 0, 0,       1, 5, 0, 0,  0,  0, 0, 0, 0, 1, 1, 5,  'h54);  // 7  commit
    add(0, 0, 0,  0, 0, 0,       1, 5, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0,  0);     // 8  idle
    add(1, 0, 7,  0, 0, 0,       0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0,  0);     // 9  mul r7
    add(0, 0, 0,  0, 0, 0,       1, 7, 0, 0,  0,  0, 1, 0, 1, 1, 0, 0,  0);     // 10
    add(0, 0, 0,  0, 0, 0,       1, 0, 0, 7,  0,  0, 0, 0, 1, 1, 0, 0,  0);     // 11 WAW
    add(0, 0, 0,  0, 0, 0,       1, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  0);     // 12 r0 sources
    add(0, 0, 0,  0, 0, 0,       1, 0, 7, 0,  0,  0, 0, 0, 1, 1, 0, 0,  0);     // 13
    add(0, 0, 0,  0, 0, 0,       0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  0);     // 14
    add(0, 0, 0,  1, 0, 'h54,    0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  0);     // 15 ready
    add(0, 0, 0,  0, 0, 0,       1, 7, 0, 0,  1,  0, 0, 0, 1, 1, 0, 0,  0);     // 16 wb conflict
    add(0, 0, 0,  0, 0, 0,       0, 0, 0, 0,  1,  0, 0, 0, 0, 1, 0, 0,  0);     // 17
    add(0, 0, 0,  0, 0, 0,       0, 0, 0, 0,  1,  0, 0, 0, 0, 1, 0, 0,  0);     // 18
    add(0, 0, 0,  0, 0, 0,       1, 7, 0, 0,  0,  0, 0, 0, 0, 1, 1, 7,  'h54);  // 19 commit
    add(0, 0, 0,  0, 0, 0,       0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0,  0);     // 20
    add(1, 0, 0,  0, 0, 0,       0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0,  0);     // 21 mul r0
    add(0, 0, 0,  0, 0, 0,       1, 0, 0, 0,  0,  0, 1, 0, 0, 1, 0, 0,  0);     // 22 no r0 hazard
    add(0, 0, 0,  1, 0, 'h99,    0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  0);     // 23 ready at k=2
    add(0, 0, 0,  0, 0, 0,       0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  0);     // 24 discarded
    add(0, 0, 0,  0, 0, 0,       0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0,  0);     // 25
    add(1, 1, 3,  0, 0, 0,       0, 0, 0, 0,  0,  1, 0, 0, 0, 0, 0, 0,  0);     // 26 div r3
    add(0, 0, 0,  0, 0, 0,       0, 0, 0, 0,  0,  0, 0, 1, 0, 1, 0, 0,  0);     // 27
    add(0, 0, 0,  1, 1, 'h1234,  0, 0, 0, 0,  0,  0, 0, 0, 0, 1, 0, 0,  0);     // 28 exception
    add(0, 0, 0,  0, 0, 0,       1, 3, 0, 0,  0,  0, 0, 0, 0, 1, 1, 30, 5);     // 29 rstatus write
    add(0, 0, 0,  0, 0, 0,       0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0,  0);     // 30

    idle_inputs();
    reset = 1;
    tick();
    tick();
    #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset commit", 32'(commit), 0);
    chk("reset commit_rd", 32'(commit_rd), 0);
    chk("reset commit_data", commit_data, 0);
    chk("reset ctrl_MULT", 32'(ctrl_MULT), 0);
    chk("reset ctrl_DIV", 32'(ctrl_DIV), 0);
    reset = 0;

    foreach (vecs[i]) begin
      issue_valid = vecs[i].iv; issue_is_div = vecs[i].idiv; issue_rd = vecs[i].ird;
      md_ready = vecs[i].rdy; md_exception = vecs[i].exc; md_result = vecs[i].res;
      fd_valid = vecs[i].fv; fd_rs = vecs[i].rs; fd_rt = vecs[i].rt; fd_rd = vecs[i].frd;
      wb_busy = vecs[i].wb;
      #1;
      chk($sformatf("v%0d issue_accept", i), 32'(issue_accept), 32'(vecs[i].e_acc));
      chk($sformatf("v%0d ctrl_MULT", i), 32'(ctrl_MULT), 32'(vecs[i].e_mul));
      chk($sformatf("v%0d ctrl_DIV", i), 32'(ctrl_DIV), 32'(vecs[i].e_div));
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d commit", i), 32'(commit), 32'(vecs[i].e_com));
      chk($sformatf("v%0d commit_rd", i), 32'(commit_rd), 32'(vecs[i].e_crd));
      chk($sformatf("v%0d commit_data", i), commit_data, vecs[i].e_cdata);
      tick();
    end

    // back-to-back: second div waits in DX while the first is in flight
    idle_inputs();
    issue_valid = 1; issue_is_div = 1; issue_rd = 4;
    #1; chk("b2b first accept", 32'(issue_accept), 1);
    tick();
    issue_rd = 6;
    #1; chk("b2b start accept", 32'(issue_accept), 0);
    chk("b2b start stall", 32'(stall), 1);
    chk("b2b start ctrl_DIV", 32'(ctrl_DIV), 1);
    tick();
    md_ready = 1; md_result = 'h77;
    #1; chk("b2b run accept", 32'(issue_accept), 0);
    chk("b2b run stall", 32'(stall), 1);
    tick();
    md_ready = 0;
    #1; chk("b2b done commit", 32'(commit), 1);
    chk("b2b done commit_rd", 32'(commit_rd), 4);
    chk("b2b done commit_data", commit_data, 'h77);
    chk("b2b done accept", 32'(issue_accept), 0);
    chk("b2b done stall", 32'(stall), 1);
    tick();
    #1; chk("b2b second accept", 32'(issue_accept), 1);
    chk("b2b second stall", 32'(stall), 0);
    tick();
    issue_valid = 0;
    pulses = 0; ccyc = -1; crd = 0; cdata = 0;
    for (int i = 0; i < 10; i++) begin
      md_ready = (i == 3); md_result = 'h88;
      #1;
      if (ctrl_DIV) pulses++;
      if (commit && ccyc < 0) begin
        ccyc = i; crd = commit_rd; cdata = commit_data;
      end
      tick();
    end
    md_ready = 0;
    chk("b2b ctrl_DIV pulses", 32'(pulses), 1);
    chk("b2b commit cycle", 32'(ccyc), 4);
    chk("b2b commit_rd", 32'(crd), 6);
    chk("b2b commit_data", cdata, 'h88);

    // reset in RUN abandons the op; later md_ready is ignored
    idle_inputs();
    issue_valid = 1; issue_rd = 9;
    #1; chk("rst accept", 32'(issue_accept), 1);
    tick();
    issue_valid = 0;
    tick();
    tick();
    reset = 1;
    #1; chk("rst busy before", 32'(busy), 1);
    tick();
    reset = 0;
    for (int c = 4; c <= 10; c++) begin
      md_ready = (c == 5); md_result = 'h55;
      #1;
      chk($sformatf("rst c%0d busy", c), 32'(busy), 0);
      chk($sformatf("rst c%0d commit", c), 32'(commit), 0);
      chk($sformatf("rst c%0d ctrl_MULT", c), 32'(ctrl_MULT), 0);
      tick();
    end
    md_ready = 0;

    // RUN with no md_ready
    issue_valid = 1; issue_rd = 11;
    #1; chk("to accept", 32'(issue_accept), 1);
    tick();
    issue_valid = 0;
`ifdef MULTDIV_TIMEOUT_EN
    ccyc = -1; crd = 0; cdata = 0;
    for (int j = 1; j <= 100; j++) begin
      #1;
      if (commit) begin
        ccyc = j; crd = commit_rd; cdata = commit_data;
      end
      tick();
      if (ccyc >= 0) break;
    end
    chk("to commit cycle", 32'(ccyc), 42);
    chk("to commit_rd", 32'(crd), 30);
    chk("to commit_data", cdata, 4);
    md_ready = 1; md_result = 'h66;
    #1; chk("to late ready busy", 32'(busy), 0);
    tick();
    md_ready = 0;
    #1; chk("to late ready commit", 32'(commit), 0);
    chk("to late ready idle", 32'(busy), 0);
    tick();
`else
    pulses = 0;
    for (int j = 1; j <= 60; j++) begin
      #1;
      if (commit || !busy) pulses++;
      tick();
    end
    chk("wait run violations", 32'(pulses), 0);
    md_ready = 1; md_result = 'hABC;
    #1;
    tick();
    md_ready = 0;
    #1; chk("wait commit", 32'(commit), 1);
    chk("wait commit_rd", 32'(commit_rd), 11);
    chk("wait commit_data", commit_data, 'hABC);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Controller that sequences the shared multi-cycle multiply/divide unit so the pipeline keeps running while a mul/div is in flight.
- Accepts one mul/div issue at a time from the DX stage and pulses the unit's start controls.
- Buffers the result or exception and arbitrates the single regfile write port against MW-stage writeback.
- Generates the hazard stall for dependent or conflicting younger instructions in FD.

Parameters:
- RSTATUS_REG, 30, register written on mul/div exception
- EXC_MUL, 4, rstatus code for multiply exception
- EXC_DIV, 5, rstatus code for divide exception
- TIMEOUT, 40, cycle limit in RUN (used only with the optional feature)

Ports:
- clock  in  1  master clock; all state on posedge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  DX holds a mul/div instruction
- issue_is_div  in  1  1=div, 0=mul
- issue_rd  in  5  destination register of the issued op
- issue_accept  out  1  combinational; issue taken this cycle
- ctrl_MULT  out  1  registered one-cycle start pulse to the unit
- ctrl_DIV  out  1  registered one-cycle start pulse to the unit
- md_ready  in  1  unit result ready (data_resultRDY)
- md_exception  in  1  unit exception, sampled with md_ready
- md_result  in  32  unit result, sampled with md_ready
- fd_valid  in  1  FD holds a real (non-bubble) instruction
- fd_rs  in  5  FD source register A
- fd_rt  in  5  FD source register B
- fd_rd  in  5  FD destination register (0 if none)
- wb_busy  in  1  MW stage writes the regfile this cycle
- stall  out  1  combinational; freeze PC/FD, bubble into DX
- busy  out  1  state != IDLE
- commit  out  1  combinational; drive regfile write from this block
- commit_rd  out  5  write register when commit=1
- commit_data  out  32  write data when commit=1

Behaviour:
- States: IDLE, START, RUN, DONE.
- Reset (synchronous): state=IDLE; ctrl_MULT=ctrl_DIV=0; pending rd, op, result and exception buffers cleared. Consequently busy=0 and commit=0. commit_rd/commit_data read 0.
- Issue:
  - issue_accept = issue_valid && state==IDLE.
  - On accept, latch issue_rd and issue_is_div, then go to START.
- START (exactly 1 cycle):
  - ctrl_DIV=is_div, ctrl_MULT=!is_div, registered and high only in this cycle.
  - Go to RUN. md_ready is ignored in START.
- RUN:
  - Wait for md_ready=1.
  - On md_ready, capture md_result and md_exception, then go to DONE.
  - No same-cycle commit: commit earliest the following cycle.
- DONE:
  - commit = !wb_busy && (exception || pending_rd!=0).
  - Non-exception: commit_rd=pending_rd, commit_data=buffered result.
  - Exception: commit_rd=RSTATUS_REG, commit_data=EXC_DIV if is_div else EXC_MUL (zero-extended).
  - On the commit cycle, go to IDLE.
  - If pending_rd==0 and no exception, the result is discarded and the block goes to IDLE without asserting commit.
  - While wb_busy=1, stay in DONE. Pipeline writeback always has priority.
- Minimum latency: accept cycle → START → RUN (≥1 cycle) → DONE commit. Accept at cycle 0 with md_ready first seen at cycle k≥2 gives commit at cycle k+1 if wb_busy=0.
- stall is high when any of the following holds:
  - issue_valid && state!=IDLE (structural; the second mul/div waits in DX and is not lost);
  - busy && fd_valid && pending_rd!=0 && (fd_rs==pending_rd || fd_rt==pending_rd || fd_rd==pending_rd) (RAW and WAW);
  - busy && fd_valid && fd_rd==RSTATUS_REG (protects the possible exception write).
- r0 never creates a RAW or WAW hazard.
- stall deasserts in the same cycle commit asserts if the only cause is the pending rd.
- Reset in any state: in-flight op abandoned, no commit, and any later md_ready is ignored while in IDLE.

Optional Feature:
- Macro MULTDIV_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT without md_ready, go to DONE with the exception flag set (rstatus write as above).
  - A later md_ready is ignored.
- Not defined: no counter; RUN waits indefinitely.

Test Plan:
- Basic mul: mul r5 accepted at cycle 0, md_ready=1 with md_result=0x0000_0054 at cycle 6, wb_busy=0 → ctrl_MULT high only at cycle 1; commit at cycle 7 with rd=5, data=0x54; busy=0 at cycle 8.
- Writeback conflict: as above but wb_busy=1 during cycles 7-9 → commit stays low; commit at cycle 10 with data=0x54.
- Hazards with r7 pending:
  - fd_rs=7 → stall=1 until the commit cycle.
  - fd_rd=7 → stall=1 (WAW).
  - fd_rs=0 with pending rd=0 → stall=0.
- Back-to-back ops: second div issued while busy → stall=1 and issue_accept=0 until IDLE; then accepted, and ctrl_DIV pulses exactly once.
- Divide exception: div r3 with md_ready=1 and md_exception=1 → commit rd=30, data=5; r3 is not written.
- Reset mid-RUN: reset at cycle 3, md_ready at cycle 5 → no commit, no ctrl pulse, state stays IDLE. With MULTDIV_TIMEOUT_EN, TIMEOUT=40 and no md_ready → commit rd=30, data=4 at 40 RUN cycles + 1.
